// File: rtl/tx_serializer_pkg.sv
// Shared 8b/10b constants and helpers for the 10-bit transmit serializer.
// Code words are packed as {j,h,g,f,i,e,d,c,b,a}, with bit 0 = a.
package tx_serializer_pkg;

  localparam int CW_WIDTH = 10;

  localparam logic [CW_WIDTH-1:0] K28_5_RDN = 10'h17C;
  localparam logic [CW_WIDTH-1:0] K28_5_RDP = 10'h283;

  localparam logic [3:0] FIRST_BIT = 4'd0;
  localparam logic [3:0] LAST_BIT  = 4'd9;

  typedef logic [CW_WIDTH-1:0] cw_t;

  function automatic logic [3:0] cw_popcount(input cw_t w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < CW_WIDTH; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

  // Idle comma chosen so that it returns the line toward neutral disparity.
  function automatic cw_t k28_5_for(input logic rd);
    cw_t w;
    if (rd) begin
      w = K28_5_RDP;
    end else begin
      w = K28_5_RDN;
    end
    return w;
  endfunction

endpackage

// File: rtl/tx_serializer_disp_check.sv
// Combinational popcount/disparity checker for one 10-bit code word.
// 6 ones drives RD+, 4 ones drives RD-, 5 ones keeps RD; other counts are illegal and keep RD.
module tx_serializer_disp_check
  import tx_serializer_pkg::*;
(
  input  logic [CW_WIDTH-1:0] word,
  input  logic                rd_in,
  output logic                rd_out,
  output logic                err
);

  logic [3:0] ones;

  always_comb begin
    ones   = cw_popcount(word);
    rd_out = rd_in;
    err    = 1'b0;
    case (ones)
      4'd4: begin
        rd_out = 1'b0;
        err    = !rd_in;
      end
      4'd5: begin
        rd_out = rd_in;
        err    = 1'b0;
      end
      4'd6: begin
        rd_out = 1'b1;
        err    = rd_in;
      end
      default: begin
        rd_out = rd_in;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tx_serializer.sv
// 10-bit word serializer with a one-word holding register and K28.5 idle fill.
// A word is loaded every 10 cycles; the stream never stalls.
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW_WIDTH-1:0] sym_in,
  input  logic                sym_valid,
  output logic                sym_ready,
  output logic                tx_rd,
  output logic                ser_out,
  output logic                word_start,
  output logic                idle_ins,
  output logic                disp_err
);

  logic [CW_WIDTH-1:0] shreg;
  logic [3:0]          bit_cnt;
  logic [CW_WIDTH-1:0] hold;
  logic                hold_valid;

  logic                load_en;
  logic                accept;
  logic                insert_idle;
  logic [CW_WIDTH-1:0] idle_word;
  logic [CW_WIDTH-1:0] next_word;
  logic [CW_WIDTH-1:0] shifted;
  logic [CW_WIDTH-1:0] chk_word;
  logic                chk_rd;
  logic                chk_err;

  always_comb begin
    load_en     = (bit_cnt == LAST_BIT);
    sym_ready   = rst | !hold_valid | load_en;
    accept      = sym_valid & sym_ready & !rst;
    idle_word   = k28_5_for(tx_rd);
    insert_idle = load_en & !hold_valid & !accept & !rst;
    word_start  = (bit_cnt == FIRST_BIT);

    if (hold_valid) begin
      next_word = hold;
    end else if (accept) begin
      next_word = sym_in;
    end else begin
      next_word = idle_word;
    end

    // Only one disparity event (data accept or idle insertion) can occur per cycle.
    if (accept) begin
      chk_word = sym_in;
    end else begin
      chk_word = idle_word;
    end

    if (LSB_FIRST) begin
      ser_out = shreg[0];
      shifted = {1'b0, shreg[CW_WIDTH-1:1]};
    end else begin
      ser_out = shreg[CW_WIDTH-1];
      shifted = {shreg[CW_WIDTH-2:0], 1'b0};
    end
  end

  tx_serializer_disp_check disp_check (
    .word   (chk_word),
    .rd_in  (tx_rd),
    .rd_out (chk_rd),
    .err    (chk_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= LAST_BIT;
      hold       <= '0;
      hold_valid <= 1'b0;
      tx_rd      <= 1'b0;
      idle_ins   <= 1'b0;
      disp_err   <= 1'b0;
    end else begin
      if (load_en) begin
        shreg   <= next_word;
        bit_cnt <= FIRST_BIT;
      end else begin
        shreg   <= shifted;
        bit_cnt <= bit_cnt + 4'd1;
      end

      // A word accepted on a load with an empty hold bypasses straight into shreg.
      if (accept && !(load_en && !hold_valid)) begin
        hold       <= sym_in;
        hold_valid <= 1'b1;
      end else if (load_en) begin
        hold_valid <= 1'b0;
      end

      if (accept || insert_idle) begin
        tx_rd <= chk_rd;
      end

      idle_ins <= insert_idle;
      disp_err <= accept & chk_err;
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Randomized self-checking bench for tx_serializer, both bit orders side by side.
// A word-level queue model predicts every output each cycle.
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic [9:0] sym_in;

  logic l_ready, l_rd, l_ser, l_ws, l_idle, l_err;
  logic m_ready, m_rd, m_ser, m_ws, m_idle, m_err;

  always #5 clk = ~clk;

  tx_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(l_ready), .tx_rd(l_rd), .ser_out(l_ser),
    .word_start(l_ws), .idle_ins(l_idle), .disp_err(l_err)
  );

  tx_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(m_ready), .tx_rd(m_rd), .ser_out(m_ser),
    .word_start(m_ws), .idle_ins(m_idle), .disp_err(m_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: word on the wire, position within it, and a pending-word queue (depth 1).
  logic [9:0] m_cur;
  int         m_idx;
  logic [9:0] m_pend[$];
  logic       m_rdv;
  logic       m_idlep;
  logic       m_errp;
  logic       m_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [9:0] d);
    int n;
    logic ready;
    if (r) begin
      m_cur = 10'h000; m_idx = 9; m_pend.delete();
      m_rdv = 1'b0; m_idlep = 1'b0; m_errp = 1'b0; m_acc = 1'b0;
      return;
    end
    ready   = (m_pend.size() == 0) || (m_idx == 9);
    m_acc   = v && ready;
    m_idlep = 1'b0;
    m_errp  = 1'b0;
    if (m_acc) begin
      n = $countones(d);
      m_errp = (n < 4) || (n > 6) || (n == 6 && m_rdv) || (n == 4 && !m_rdv);
      if (n == 6) m_rdv = 1'b1;
      else if (n == 4) m_rdv = 1'b0;
      m_pend.push_back(d);
    end
    if (m_idx == 9) begin
      if (m_pend.size() > 0) begin
        m_cur = m_pend.pop_front();
      end else begin
        m_cur   = m_rdv ? 10'h283 : 10'h17C;
        m_idlep = 1'b1;
        m_rdv   = !m_rdv;
      end
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] d);
    logic exp_ready;
    rst = r; sym_valid = v; sym_in = d;
    #1;
    exp_ready = r || (m_pend.size() == 0) || (m_idx == 9);
    check_val("sym_ready_lsb", 32'(l_ready), 32'(exp_ready));
    check_val("sym_ready_msb", 32'(m_ready), 32'(exp_ready));
    model_update(r, v, d);
    @(posedge clk);
    #1;
    check_val("ser_out_lsb", 32'(l_ser), 32'(m_cur[m_idx]));
    check_val("ser_out_msb", 32'(m_ser), 32'(m_cur[9 - m_idx]));
    check_val("word_start", 32'({l_ws, m_ws}), 32'({2{m_idx == 0}}));
    check_val("tx_rd", 32'({l_rd, m_rd}), 32'({2{m_rdv}}));
    check_val("idle_ins", 32'({l_idle, m_idle}), 32'({2{m_idlep}}));
    check_val("disp_err", 32'({l_err, m_err}), 32'({2{m_errp}}));
  endtask

  task automatic send_word(input logic [9:0] w);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 1'b1, w);
      done = m_acc;
    end
    check_val("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain_to(input int idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1'b0, 1'b0, 10'h000);
      hit = (m_idx == idx) && (m_pend.size() == 0);
    end
    check_val("drain_reached", 32'(hit), 32'd1);
  endtask

  logic [9:0] lbits, mbits;
  int         cnt;
  logic [9:0] choices [8];
  logic [9:0] w;

  initial begin
    m_cur = 10'h000; m_idx = 9; m_rdv = 1'b0; m_idlep = 1'b0; m_errp = 1'b0; m_acc = 1'b0;
    choices[0] = 10'h17C; choices[1] = 10'h283; choices[2] = 10'h2AA; choices[3] = 10'h155;
    choices[4] = 10'h3FF; choices[5] = 10'h000; choices[6] = 10'h0F8; choices[7] = 10'h307;

    // Reset state and idle fill after reset.
    repeat (3) step(1'b1, 1'b0, 10'h000);
    check_val("reset_ser_out", 32'({l_ser, m_ser}), 32'd0);
    check_val("reset_ws", 32'({l_ws, m_ws}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 10'h000);
      lbits[i] = l_ser; mbits[9 - i] = m_ser;
    end
    check_val("idle1_lsb", 32'(lbits), 32'h17C);
    check_val("idle1_msb", 32'(mbits), 32'h17C);
    check_val("idle1_rd", 32'(l_rd), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 10'h000);
      lbits[i] = l_ser; mbits[9 - i] = m_ser;
    end
    check_val("idle2_lsb", 32'(lbits), 32'h283);
    check_val("idle2_msb", 32'(mbits), 32'h283);

    // Continuous balanced data: no idles, one load per 10 cycles.
    cnt = 0; w = 10'h2AA;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, w);
      if (m_acc) w = (w == 10'h2AA) ? 10'h155 : 10'h2AA;
      if (l_idle || m_idle) cnt++;
    end
    check_val("stream_no_idle", 32'(cnt), 32'd0);

    // Illegal popcount word.
    drain_to(9);
    cnt = 0;
    send_word(10'h3FF);
    if (l_err) cnt++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 10'h000);
      if (l_err) cnt++;
    end
    check_val("err_3ff_once", 32'(cnt), 32'd1);

    // Disparity-direction errors.
    send_word(10'h283);
    send_word(10'h17C);
    send_word(10'h17C);
    check_val("err_6_at_rdp", 32'(l_err), 32'd1);
    send_word(10'h283);
    check_val("ok_4_at_rdp", 32'(l_err), 32'd0);
    check_val("rd_after_283", 32'(l_rd), 32'd0);

    // Bypass on a load cycle with empty hold.
    drain_to(9);
    step(1'b0, 1'b1, 10'h2AA);
    check_val("bypass_ws", 32'(l_ws), 32'd1);
    check_val("bypass_no_idle", 32'(l_idle), 32'd0);

    // Mid-word reset with hold full.
    drain_to(9);
    step(1'b0, 1'b1, 10'h155);
    step(1'b0, 1'b1, 10'h2AA);
    for (int i = 0; i < 10 && m_idx != 4; i++) step(1'b0, 1'b0, 10'h000);
    check_val("pre_reset_hold_full", 32'(m_pend.size()), 32'd1);
    step(1'b1, 1'b0, 10'h000);
    check_val("midreset_ser_out", 32'({l_ser, m_ser}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 10'h000);
      lbits[i] = l_ser;
      if (i == 0) check_val("post_reset_idle", 32'(l_idle), 32'd1);
    end
    check_val("post_reset_word", 32'(lbits), 32'h17C);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b1, 1'b0, 10'h000);
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b1, 10'($urandom));
      end else begin
        step(1'b0, $urandom_range(0, 3) != 0, choices[$urandom_range(0, 7)]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = code-word bit 0 (a) transmitted first; 0 = bit 9 (j) first.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- sym_in  in  10  encoded code word {j,h,g,f,i,e,d,c,b,a}
- sym_valid  in  1  sym_in valid
- sym_ready  out  1  word accepted on sym_valid & sym_ready
- tx_rd  out  1  running disparity after last accepted or idle word (0 = RD-, 1 = RD+); drives upstream encoder dispin
- ser_out  out  1  serial bit, one per clk
- word_start  out  1  high while ser_out carries the first bit of a word
- idle_ins  out  1  one-cycle pulse: K28.5 idle inserted
- disp_err  out  1  one-cycle pulse: accepted word violated disparity rules

Function
REQ-004 SHALL hold one word in a holding register (hold, hold_valid) ahead of a 10-bit shift register (shreg) and 4-bit bit counter bit_cnt (0..9).
REQ-005 SHALL define load_en = (bit_cnt == 9); on load_en shreg loads the next word and bit_cnt becomes 0; otherwise shreg shifts toward the transmit end and bit_cnt increments.
REQ-006 SHALL drive ser_out directly from the transmit end of shreg (bit 0 when LSB_FIRST=1), so the first bit of a loaded word appears the cycle after load_en.
REQ-007 SHALL assert word_start when bit_cnt == 0.
REQ-008 SHALL drive sym_ready = !hold_valid | load_en, combinationally.
REQ-009 On load_en, next-word priority SHALL be: hold (if hold_valid), else sym_in bypass (if accepted this cycle), else the idle word.
REQ-010 Accept with load_en & hold_valid SHALL move hold to shreg and refill hold with sym_in in the same cycle.
REQ-011 The idle word SHALL be K28.5: 10'h17C when tx_rd=0, 10'h283 when tx_rd=1; idle_ins SHALL pulse the cycle after insertion.
REQ-012 SHALL update tx_rd at acceptance (data) or insertion (idle), in transmission order: word with 6 ones -> 1, 4 ones -> 0, 5 ones -> unchanged.
REQ-013 SHALL flag disp_err (registered, next cycle) when an accepted word has a popcount outside {4,5,6}, 6 ones while tx_rd=1, or 4 ones while tx_rd=0; the word is still transmitted, and tx_rd is unchanged if popcount is outside {4,5,6}.
REQ-014 SHALL never stall the serial stream: every 10 cycles exactly one word (data or idle) is loaded.

Reset
REQ-015 While rst is high: shreg=0, ser_out=0, bit_cnt=9, hold_valid=0, tx_rd=0, idle_ins=0, disp_err=0, word_start=0, sym_ready=1; no word is accepted.
REQ-016 Reset asserted mid-word SHALL abort the word and discard hold; the first cycle after reset is a load_en cycle.

Structure
REQ-017 SHALL place K28_5_RDN (10'h17C), K28_5_RDP (10'h283) and the code-word width constant (10) in the shared 8b/10b package.
REQ-018 SHALL instantiate one sub-module, disp_check: combinational popcount/disparity checker (word, rd_in -> rd_out, err).

Verification
REQ-019 Reset, sym_valid=0: the first word is 10'h17C, giving ser_out 0,0,1,1,1,1,1,0,1,0 with idle_ins pulsing and tx_rd -> 1; the second word is 10'h283.
REQ-020 Continuous sym_valid of words 10'h2AA and 10'h155 (5 ones): no idle_ins, one load every 10 cycles, tx_rd unchanged, bit order checked against LSB_FIRST=1 and 0.
REQ-021 sym_in = 10'h3FF accepted: disp_err pulses once, the word is transmitted, and tx_rd is unchanged.
REQ-022 With tx_rd=1, accept 10'h17C (6 ones): disp_err pulses; accept 10'h283 (4 ones): no error and tx_rd -> 0.
REQ-023 With hold empty, sym_valid rising exactly on a load_en cycle: bypass into shreg with no idle inserted, and word_start the next cycle.
REQ-024 Reset pulsed at bit_cnt=4 with hold full: ser_out=0 and hold discarded; after release, a load occurs on the first cycle and the idle is 10'h17C.
